// File: rtl/rf_32x32_ctrl_pkg.sv
// Shared types and constants for the 32x32 1R1W register-file macro controller.
package rf_32x32_ctrl_pkg;

  // Address width for an array of els entries; never narrower than one bit.
  function automatic int unsigned addr_width(input int unsigned els);
    return (els > 1) ? $clog2(els) : 1;
  endfunction

  localparam int unsigned width_lp        = 32;
  localparam int unsigned els_lp          = 32;
  localparam int unsigned addr_width_lp   = addr_width(els_lp);
  localparam logic [2:0]  ema_default_lp  = 3'b010;
  localparam logic        emas_default_lp = 1'b0;

  typedef enum logic [1:0] {
    INIT   = 2'd0,
    RUN    = 2'd1,
    REPLAY = 2'd2
  } state_e;

endpackage

// File: rtl/rf_32x32_macro_ctrl_if.sv
// Core-side request/response bundle; signal suffixes follow the controller's view.
interface rf_32x32_macro_ctrl_if
  import rf_32x32_ctrl_pkg::*;
#(
  parameter int unsigned width_p      = width_lp,
  parameter int unsigned addr_width_p = addr_width_lp
);
  logic                    ready_o;
  logic                    r_v_i;
  logic [addr_width_p-1:0] r_addr_i;
  logic                    r_yumi_o;
  logic                    r_v_o;
  logic [width_p-1:0]      r_data_o;
  logic                    w_v_i;
  logic [addr_width_p-1:0] w_addr_i;
  logic [width_p-1:0]      w_data_i;
  logic [width_p-1:0]      w_mask_i;

  modport slave (
    output ready_o, r_yumi_o, r_v_o, r_data_o,
    input  r_v_i, r_addr_i, w_v_i, w_addr_i, w_data_i, w_mask_i
  );

  modport master (
    input  ready_o, r_yumi_o, r_v_o, r_data_o,
    output r_v_i, r_addr_i, w_v_i, w_addr_i, w_data_i, w_mask_i
  );
endinterface

// File: rtl/rf_32x32_clr_counter.sv
// Post-reset clear address counter; done_o is high while the last address is presented.
module rf_32x32_clr_counter
  import rf_32x32_ctrl_pkg::*;
#(
  parameter  int unsigned els_p = els_lp,
  localparam int unsigned aw_lp = addr_width(els_p)
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             en_i,
  output logic [aw_lp-1:0] cnt_o,
  output logic             done_o
);

  localparam logic [aw_lp-1:0] last_lp = aw_lp'(els_p - 1);

  logic [aw_lp-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;

  // Advance and wrap the address; flag the cycle that holds the last address.
  always_comb begin
    cnt_d = cnt_q;
    if (en_i) begin
      cnt_d = (cnt_q == last_lp) ? '0 : cnt_q + aw_lp'(1);
    end
    done_d = (cnt_d == last_lp);
  end

  // Counter and done flag registers.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign done_o = done_q;

endmodule

// File: rtl/rf_32x32_macro_ctrl.sv
// Controller for a 32x32 1R1W register-file hard macro: clears the array after
// reset, maps core read/write requests onto macro pins and resolves same-address
// read/write collisions by replaying the read after the write.
// Optional: define RF_32X32_CTRL_COLL_FWD_EN to forward full-mask collisions.
module rf_32x32_macro_ctrl
  import rf_32x32_ctrl_pkg::*;
#(
  parameter  int unsigned width_p = width_lp,
  parameter  int unsigned els_p   = els_lp,
  parameter  logic [2:0]  ema_p   = ema_default_lp,
  parameter  logic        emas_p  = emas_default_lp,
  localparam int unsigned aw_lp   = addr_width(els_p)
) (
  input  logic               clk_i,
  input  logic               reset_i,
  rf_32x32_macro_ctrl_if.slave bus,
  output logic               cena_o,
  output logic [aw_lp-1:0]   aa_o,
  input  logic [width_p-1:0] qa_i,
  output logic               cenb_o,
  output logic [width_p-1:0] wenb_o,
  output logic [aw_lp-1:0]   ab_o,
  output logic [width_p-1:0] db_o,
  output logic [2:0]         emaa_o,
  output logic [2:0]         emab_o,
  output logic               emasa_o,
  output logic               ret1n_o,
  output logic               colldisn_o
);

  state_e             state_q, state_d;
  logic               r_v_q, r_v_d;
  logic               ready_q;
  logic [aw_lp-1:0]   raddr_q, raddr_d;
  logic [width_p-1:0] hold_q;
  logic [width_p-1:0] rd_src_c;
  logic               coll_c, fwd_c, r_yumi_c, clr_en_c, clr_done;
  logic [aw_lp-1:0]   clr_cnt;

  rf_32x32_clr_counter #(.els_p(els_p)) u_clr (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .en_i    (clr_en_c),
    .cnt_o   (clr_cnt),
    .done_o  (clr_done)
  );

  assign coll_c = bus.w_v_i & bus.r_v_i & (bus.r_addr_i == bus.w_addr_i);

`ifdef RF_32X32_CTRL_COLL_FWD_EN
  logic               fwd_q;
  logic [width_p-1:0] fwd_data_q;

  assign fwd_c    = coll_c & (&bus.w_mask_i);
  assign rd_src_c = fwd_q ? fwd_data_q : qa_i;

  // Capture write data of a forwarded full-mask collision.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      fwd_q      <= 1'b0;
      fwd_data_q <= '0;
    end else begin
      fwd_q <= fwd_c & (state_q == RUN);
      if (fwd_c) fwd_data_q <= bus.w_data_i;
    end
  end
`else
  assign fwd_c    = 1'b0;
  assign rd_src_c = qa_i;
`endif

  // Next-state and macro pin decode; reset forces the macro idle.
  always_comb begin
    state_d  = state_q;
    r_v_d    = 1'b0;
    raddr_d  = raddr_q;
    r_yumi_c = 1'b0;
    clr_en_c = 1'b0;
    cena_o   = 1'b1;
    aa_o     = '0;
    cenb_o   = 1'b1;
    wenb_o   = '1;
    ab_o     = '0;
    db_o     = '0;
    unique case (state_q)
      INIT: begin
        clr_en_c = 1'b1;
        cenb_o   = 1'b0;
        wenb_o   = '0;
        ab_o     = clr_cnt;
        if (clr_done) state_d = RUN;
      end
      RUN: begin
        cenb_o = ~bus.w_v_i;
        wenb_o = ~bus.w_mask_i;
        ab_o   = bus.w_addr_i;
        db_o   = bus.w_data_i;
        if (coll_c && !fwd_c) begin
          raddr_d = bus.r_addr_i;
          state_d = REPLAY;
        end else if (bus.r_v_i) begin
          r_yumi_c = 1'b1;
          r_v_d    = 1'b1;
          if (!fwd_c) begin
            cena_o = 1'b0;
            aa_o   = bus.r_addr_i;
          end
        end
      end
      REPLAY: begin
        cena_o  = 1'b0;
        aa_o    = raddr_q;
        r_v_d   = 1'b1;
        state_d = RUN;
      end
      default: state_d = INIT;
    endcase
    if (reset_i) begin
      r_yumi_c = 1'b0;
      clr_en_c = 1'b0;
      cena_o   = 1'b1;
      cenb_o   = 1'b1;
      wenb_o   = '1;
    end
  end

  // State, read-valid and held read data registers.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= INIT;
      r_v_q   <= 1'b0;
      ready_q <= 1'b0;
      raddr_q <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      r_v_q   <= r_v_d;
      ready_q <= (state_d == RUN);
      raddr_q <= raddr_d;
      if (r_v_q) hold_q <= rd_src_c;
    end
  end

  assign bus.ready_o  = ready_q;
  assign bus.r_yumi_o = r_yumi_c;
  assign bus.r_v_o    = r_v_q;
  assign bus.r_data_o = r_v_q ? rd_src_c : hold_q;

  assign emaa_o     = ema_p;
  assign emab_o     = ema_p;
  assign emasa_o    = emas_p;
  assign ret1n_o    = 1'b1;
  assign colldisn_o = 1'b1;

endmodule

// File: tb/tb_rf_32x32_macro_ctrl.sv
// Self-checking bench for rf_32x32_macro_ctrl with a behavioural macro model.
module tb_rf_32x32_macro_ctrl;

  logic clk = 1'b0;
  logic reset_i;
  always #5 clk = ~clk;

  rf_32x32_macro_ctrl_if bus_if ();

  logic        cena, cenb;
  logic [4:0]  aa, ab;
  logic [31:0] qa, wenb, db;
  logic [2:0]  emaa, emab;
  logic        emasa, ret1n, colldisn;

  rf_32x32_macro_ctrl dut (
    .clk_i      (clk),
    .reset_i    (reset_i),
    .bus        (bus_if),
    .cena_o     (cena),
    .aa_o       (aa),
    .qa_i       (qa),
    .cenb_o     (cenb),
    .wenb_o     (wenb),
    .ab_o       (ab),
    .db_o       (db),
    .emaa_o     (emaa),
    .emab_o     (emab),
    .emasa_o    (emasa),
    .ret1n_o    (ret1n),
    .colldisn_o (colldisn)
  );

  // Behavioural macro: starts with non-zero contents so the clear is observable.
  logic [31:0] mem [32];
  logic        filled = 1'b0;
  always @(posedge clk) begin
    if (!filled) begin
      for (int i = 0; i < 32; i++) mem[i] <= 32'hBAD0_0000 | 32'(i);
      filled <= 1'b1;
    end else begin
      if (!cena) qa <= mem[aa];
      if (!cenb) mem[ab] <= (mem[ab] & wenb) | (db & ~wenb);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] ref_mem [32];

  logic        s_ready, s_yumi, s_rv, s_cena, s_cenb;
  logic [31:0] s_rdata, s_wenb, s_db;
  logic [4:0]  s_aa, s_ab;

  // Sample at the falling edge, score any returned read, advance to posedge+1.
  task automatic tick();
    logic [31:0] e;
    @(negedge clk);
    s_ready = bus_if.ready_o;  s_yumi = bus_if.r_yumi_o;
    s_rv    = bus_if.r_v_o;    s_rdata = bus_if.r_data_o;
    s_cena  = cena;  s_aa = aa;  s_cenb = cenb;
    s_wenb  = wenb;  s_ab = ab;  s_db = db;
    if (s_rv === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected r_data_o=%h with no read outstanding", s_rdata);
      end else begin
        e = exp_q.pop_front();
        if (s_rdata !== e) begin
          errors++;
          $display("FAIL sb_rdata got %h exp %h", s_rdata, e);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  // One request cycle; non-colliding reads are scored against pre-write contents.
  task automatic drive(input logic rv, input logic [4:0] ra, input logic wv,
                       input logic [4:0] wa, input logic [31:0] wd, input logic [31:0] wm);
    bus_if.r_v_i = rv;  bus_if.r_addr_i = ra;
    bus_if.w_v_i = wv;  bus_if.w_addr_i = wa;
    bus_if.w_data_i = wd;  bus_if.w_mask_i = wm;
    if (rv && !(wv && ra == wa)) exp_q.push_back(ref_mem[ra]);
    if (wv) ref_mem[wa] = (ref_mem[wa] & ~wm) | (wd & wm);
    tick();
    bus_if.r_v_i = 1'b0;
    bus_if.w_v_i = 1'b0;
  endtask

  task automatic test_reset();
    reset_i = 1'b1;
    tick();
    tick();
    checks++;
    if (s_ready !== 1'b0 || s_yumi !== 1'b0 || s_rv !== 1'b0 || s_rdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_core ready=%b yumi=%b rv=%b rdata=%h exp 0 0 0 0", s_ready, s_yumi, s_rv, s_rdata);
    end
    checks++;
    if (s_cena !== 1'b1 || s_cenb !== 1'b1 || s_wenb !== 32'hFFFF_FFFF) begin
      errors++;
      $display("FAIL reset_macro cena=%b cenb=%b wenb=%h exp 1 1 ffffffff", s_cena, s_cenb, s_wenb);
    end
    checks++;
    if (emaa !== 3'b010 || emab !== 3'b010 || emasa !== 1'b0 || ret1n !== 1'b1 || colldisn !== 1'b1) begin
      errors++;
      $display("FAIL tieoffs emaa=%b emab=%b emasa=%b ret1n=%b colldisn=%b exp 010 010 0 1 1",
               emaa, emab, emasa, ret1n, colldisn);
    end
    reset_i = 1'b0;
    for (int i = 0; i < 32; i++) begin
      tick();
      checks++;
      if (s_cenb !== 1'b0 || s_wenb !== 32'h0 || s_db !== 32'h0 || s_ab !== 5'(i) || s_ready !== 1'b0) begin
        errors++;
        $display("FAIL init_clear cyc=%0d cenb=%b wenb=%h db=%h ab=%0d ready=%b exp 0 0 0 %0d 0",
                 i, s_cenb, s_wenb, s_db, s_ab, i, s_ready);
      end
    end
    tick();
    checks++;
    if (s_ready !== 1'b1 || s_cenb !== 1'b1) begin
      errors++;
      $display("FAIL ready_rise ready=%b cenb=%b exp 1 1", s_ready, s_cenb);
    end
    for (int i = 0; i < 32; i++) ref_mem[i] = 32'h0;
    drive(1'b1, 5'd7, 1'b0, 5'd0, 32'h0, 32'h0);
    checks++;
    if (s_yumi !== 1'b1 || s_cena !== 1'b0 || s_aa !== 5'd7) begin
      errors++;
      $display("FAIL read7_issue yumi=%b cena=%b aa=%0d exp 1 0 7", s_yumi, s_cena, s_aa);
    end
    tick();
    checks++;
    if (s_rv !== 1'b1 || s_rdata !== 32'h0) begin
      errors++;
      $display("FAIL read7_data rv=%b rdata=%h exp 1 00000000", s_rv, s_rdata);
    end
  endtask

  task automatic test_write_read();
    drive(1'b0, 5'd0, 1'b1, 5'd5, 32'hDEAD_BEEF, 32'hFFFF_FFFF);
    checks++;
    if (s_cenb !== 1'b0 || s_ab !== 5'd5 || s_db !== 32'hDEAD_BEEF || s_wenb !== 32'h0 || s_cena !== 1'b1) begin
      errors++;
      $display("FAIL wr_pins cenb=%b ab=%0d db=%h wenb=%h cena=%b exp 0 5 deadbeef 0 1",
               s_cenb, s_ab, s_db, s_wenb, s_cena);
    end
    drive(1'b1, 5'd5, 1'b0, 5'd0, 32'h0, 32'h0);
    tick();
    checks++;
    if (s_rv !== 1'b1 || s_rdata !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL rd5_full rv=%b rdata=%h exp 1 deadbeef", s_rv, s_rdata);
    end
    tick();
    checks++;
    if (s_rv !== 1'b0 || s_rdata !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL rd5_hold rv=%b rdata=%h exp 0 deadbeef", s_rv, s_rdata);
    end
  endtask

  task automatic test_partial();
    drive(1'b0, 5'd0, 1'b1, 5'd5, 32'h0000_FFFF, 32'h0000_00FF);
    checks++;
    if (s_wenb !== 32'hFFFF_FF00 || s_cenb !== 1'b0) begin
      errors++;
      $display("FAIL partial_wenb wenb=%h cenb=%b exp ffffff00 0", s_wenb, s_cenb);
    end
    drive(1'b0, 5'd0, 1'b1, 5'd5, 32'h1234_0000, 32'h0);
    checks++;
    if (s_cenb !== 1'b0 || s_wenb !== 32'hFFFF_FFFF) begin
      errors++;
      $display("FAIL zero_mask_pulse cenb=%b wenb=%h exp 0 ffffffff", s_cenb, s_wenb);
    end
    drive(1'b1, 5'd5, 1'b0, 5'd0, 32'h0, 32'h0);
    tick();
    checks++;
    if (s_rv !== 1'b1 || s_rdata !== 32'hDEAD_BEFF) begin
      errors++;
      $display("FAIL rd5_partial rv=%b rdata=%h exp 1 deadbeff", s_rv, s_rdata);
    end
  endtask

  task automatic test_collision();
    bus_if.r_v_i = 1'b1;  bus_if.r_addr_i = 5'd9;
    bus_if.w_v_i = 1'b1;  bus_if.w_addr_i = 5'd9;
    bus_if.w_data_i = 32'h1234_5678;  bus_if.w_mask_i = 32'hFFFF_FFFF;
    ref_mem[9] = 32'h1234_5678;
    exp_q.push_back(ref_mem[9]);
    tick();
    bus_if.r_v_i = 1'b0;
    bus_if.w_v_i = 1'b0;
`ifdef RF_32X32_CTRL_COLL_FWD_EN
    checks++;
    if (s_yumi !== 1'b1 || s_cena !== 1'b1 || s_cenb !== 1'b0) begin
      errors++;
      $display("FAIL coll_fwd_issue yumi=%b cena=%b cenb=%b exp 1 1 0", s_yumi, s_cena, s_cenb);
    end
    tick();
    checks++;
    if (s_rv !== 1'b1 || s_rdata !== 32'h1234_5678 || s_cena !== 1'b1 || s_ready !== 1'b1) begin
      errors++;
      $display("FAIL coll_fwd_data rv=%b rdata=%h cena=%b ready=%b exp 1 12345678 1 1",
               s_rv, s_rdata, s_cena, s_ready);
    end
`else
    checks++;
    if (s_yumi !== 1'b0 || s_cena !== 1'b1 || s_cenb !== 1'b0) begin
      errors++;
      $display("FAIL coll_issue yumi=%b cena=%b cenb=%b exp 0 1 0", s_yumi, s_cena, s_cenb);
    end
    tick();
    checks++;
    if (s_ready !== 1'b0 || s_cena !== 1'b0 || s_aa !== 5'd9 || s_rv !== 1'b0 || s_cenb !== 1'b1) begin
      errors++;
      $display("FAIL coll_replay ready=%b cena=%b aa=%0d rv=%b cenb=%b exp 0 0 9 0 1",
               s_ready, s_cena, s_aa, s_rv, s_cenb);
    end
    tick();
    checks++;
    if (s_rv !== 1'b1 || s_rdata !== 32'h1234_5678 || s_ready !== 1'b1) begin
      errors++;
      $display("FAIL coll_data rv=%b rdata=%h ready=%b exp 1 12345678 1", s_rv, s_rdata, s_ready);
    end
`endif
  endtask

  task automatic test_back_to_back();
    for (int i = 1; i <= 3; i++) drive(1'b0, 5'd0, 1'b1, 5'(i), 32'h111 * 32'(i), 32'hFFFF_FFFF);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 5'(i + 1), 1'b1, 5'(i + 4), 32'hA + 32'(i), 32'hFFFF_FFFF);
      checks++;
      if (s_yumi !== 1'b1 || s_ready !== 1'b1 || s_cena !== 1'b0 || s_cenb !== 1'b0 || s_rv !== (i > 0)) begin
        errors++;
        $display("FAIL b2b_cycle i=%0d yumi=%b ready=%b cena=%b cenb=%b rv=%b exp 1 1 0 0 %0d",
                 i, s_yumi, s_ready, s_cena, s_cenb, s_rv, (i > 0));
      end
    end
    tick();
    checks++;
    if (s_rv !== 1'b1 || s_rdata !== 32'h333) begin
      errors++;
      $display("FAIL b2b_last rv=%b rdata=%h exp 1 00000333", s_rv, s_rdata);
    end
    tick();
    checks++;
    if (s_rv !== 1'b0) begin
      errors++;
      $display("FAIL b2b_drain rv=%b exp 0", s_rv);
    end
    for (int i = 4; i <= 6; i++) drive(1'b1, 5'(i), 1'b0, 5'd0, 32'h0, 32'h0);
    tick();
    tick();
  endtask

  task automatic test_reset_replay();
    bus_if.r_v_i = 1'b1;  bus_if.r_addr_i = 5'd12;
    bus_if.w_v_i = 1'b1;  bus_if.w_addr_i = 5'd12;
    bus_if.w_data_i = 32'h55AA_55AA;  bus_if.w_mask_i = 32'h0000_FFFF;
    tick();
    bus_if.r_v_i = 1'b0;
    bus_if.w_v_i = 1'b0;
    checks++;
    if (s_yumi !== 1'b0) begin
      errors++;
      $display("FAIL rr_coll yumi=%b exp 0", s_yumi);
    end
    reset_i = 1'b1;
    tick();
    checks++;
    if (s_ready !== 1'b0) begin
      errors++;
      $display("FAIL rr_in_replay ready=%b exp 0", s_ready);
    end
    reset_i = 1'b0;
    for (int i = 0; i < 32; i++) begin
      tick();
      checks++;
      if (s_rv !== 1'b0 || s_cenb !== 1'b0 || s_ab !== 5'(i)) begin
        errors++;
        $display("FAIL rr_init cyc=%0d rv=%b cenb=%b ab=%0d exp 0 0 %0d", i, s_rv, s_cenb, s_ab, i);
      end
    end
    tick();
    checks++;
    if (s_ready !== 1'b1) begin
      errors++;
      $display("FAIL rr_ready ready=%b exp 1", s_ready);
    end
    for (int i = 0; i < 32; i++) ref_mem[i] = 32'h0;
    for (int i = 0; i < 32; i++) drive(1'b1, 5'(i), 1'b0, 5'd0, 32'h0, 32'h0);
    tick();
    tick();
  endtask

  initial begin
    reset_i = 1'b1;
    bus_if.r_v_i = 1'b0;  bus_if.r_addr_i = '0;
    bus_if.w_v_i = 1'b0;  bus_if.w_addr_i = '0;
    bus_if.w_data_i = '0;  bus_if.w_mask_i = '0;
    test_reset();
    test_write_read();
    test_partial();
    test_collision();
    test_back_to_back();
    test_reset_replay();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover outstanding=%0d exp 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
